// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: decodes instructions into EX/WB control with stall/flush, forwarding, GPIO CSR window and instret.
// Define RV32M_EN to decode MUL/MULH/MULHU; otherwise those encodings are illegal.
module decode_ctrl_pipe #(
    parameter int NUM_IO = 3,
    parameter logic [NUM_IO-1:0] IN_MASK = 3'b011,
    parameter int CNT_W = 32,
    localparam int RW = NUM_IO > 1 ? $clog2(NUM_IO) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    output logic              valid_EX,
    output logic [3:0]        aluop_EX,
    output logic              alusrc_EX,
    output logic [1:0]        regsel_EX,
    output logic              regwrite_EX,
    output logic [4:0]        rd_EX,
    output logic [NUM_IO-1:0] gpio_we_EX,
    output logic [RW-1:0]     gpio_rsel_EX,
    output logic              illegal_EX,
    output logic              regwrite_WB,
    output logic [4:0]        rd_WB,
    output logic [1:0]        regsel_WB,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [CNT_W-1:0]  instret
);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [11:0] csr;
    logic [3:0] idx;
    logic [15:0] mask16;
    logic live, in_win, r_ok, i_ok;
    logic [3:0] r_op, i_op;
    logic d_illegal, d_alusrc, d_wr;
    logic [3:0] d_aluop;
    logic [1:0] d_regsel;
    logic [4:0] d_rd;
    logic [NUM_IO-1:0] d_we;
    logic [RW-1:0] d_rsel;
    assign op = instr[6:0];
    assign rd = instr[11:7];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign csr = instr[31:20];
    assign idx = csr[3:0];
    assign mask16 = 16'(IN_MASK);
    assign in_win = csr[11:8] == 4'hF && 32'(csr[7:0]) < NUM_IO;
    // flush shares the bubble path with valid_in=0
    assign live = valid_in && !flush;
    always_comb begin
        r_ok = 1'b1;
        r_op = 4'b0000;
        case ({f7, f3})
            {7'h00, 3'b000}: r_op = 4'b0011;
            {7'h20, 3'b000}: r_op = 4'b0100;
            {7'h00, 3'b001}: r_op = 4'b1000;
            {7'h00, 3'b010}: r_op = 4'b1100;
            {7'h00, 3'b011}: r_op = 4'b1101;
            {7'h00, 3'b100}: r_op = 4'b0010;
            {7'h00, 3'b101}: r_op = 4'b1001;
            {7'h20, 3'b101}: r_op = 4'b1010;
            {7'h00, 3'b110}: r_op = 4'b0001;
            {7'h00, 3'b111}: r_op = 4'b0000;
`ifdef RV32M_EN
            {7'h01, 3'b000}: r_op = 4'b0101;
            {7'h01, 3'b001}: r_op = 4'b0110;
            {7'h01, 3'b011}: r_op = 4'b0111;
`endif
            default: r_ok = 1'b0;
        endcase
    end
    always_comb begin
        i_ok = 1'b1;
        i_op = 4'b0000;
        case (f3)
            3'b000: i_op = 4'b0011;
            3'b100: i_op = 4'b0010;
            3'b110: i_op = 4'b0001;
            3'b111: i_op = 4'b0000;
            3'b001: begin i_op = 4'b1000; i_ok = f7 == 7'h00; end
            3'b101: begin i_op = f7 == 7'h20 ? 4'b1010 : 4'b1001; i_ok = f7 == 7'h00 || f7 == 7'h20; end
            default: i_ok = 1'b0;
        endcase
    end
    always_comb begin
        d_illegal = 1'b0;
        d_aluop = 4'b0000;
        d_alusrc = 1'b0;
        d_regsel = 2'b00;
        d_wr = 1'b0;
        d_we = '0;
        d_rsel = '0;
        if (live) begin
            if (op == 7'h33 && r_ok) begin
                d_aluop = r_op;
                d_regsel = 2'b10;
                d_wr = 1'b1;
            end else if (op == 7'h13 && i_ok) begin
                d_aluop = i_op;
                d_alusrc = 1'b1;
                d_regsel = 2'b10;
                d_wr = 1'b1;
            end else if (op == 7'h37) begin
                d_regsel = 2'b01;
                d_wr = 1'b1;
            end else if (op == 7'h73 && f3 == 3'b001 && in_win) begin
                if (mask16[idx]) begin
                    d_wr = 1'b1;
                    d_rsel = RW'(idx);
                end else d_we = NUM_IO'(1) << idx;
            end else d_illegal = 1'b1;
        end
        d_wr = d_wr && rd != 5'd0;
        d_rd = d_wr ? rd : 5'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_EX <= 1'b0;
            aluop_EX <= '0;
            alusrc_EX <= 1'b0;
            regsel_EX <= '0;
            regwrite_EX <= 1'b0;
            rd_EX <= '0;
            gpio_we_EX <= '0;
            gpio_rsel_EX <= '0;
            illegal_EX <= 1'b0;
            regwrite_WB <= 1'b0;
            rd_WB <= '0;
            regsel_WB <= '0;
            instret <= '0;
        end else begin
            if (flush || !stall) begin
                valid_EX <= live;
                aluop_EX <= d_aluop;
                alusrc_EX <= d_alusrc;
                regsel_EX <= d_regsel;
                regwrite_EX <= d_wr;
                rd_EX <= d_rd;
                gpio_we_EX <= d_we;
                gpio_rsel_EX <= d_rsel;
                illegal_EX <= d_illegal;
            end
            regwrite_WB <= !stall && valid_EX && regwrite_EX;
            rd_WB <= stall ? 5'd0 : rd_EX;
            regsel_WB <= stall ? 2'b00 : regsel_EX;
            if (valid_EX && !illegal_EX && !stall) instret <= instret + CNT_W'(1);
        end
    end
    assign fwd_a = regwrite_EX && valid_EX && rd_EX != 5'd0 && rd_EX == instr[19:15];
    assign fwd_b = regwrite_EX && valid_EX && rd_EX != 5'd0 && rd_EX == instr[24:20];
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: table-driven decode vectors plus hand-written pipeline sequences.
module tb_decode_ctrl_pipe;
    logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] instr = '0;
    logic valid_EX, alusrc_EX, regwrite_EX, illegal_EX, regwrite_WB, fwd_a, fwd_b;
    logic [3:0] aluop_EX;
    logic [1:0] regsel_EX, regsel_WB, gpio_rsel_EX;
    logic [4:0] rd_EX, rd_WB;
    logic [2:0] gpio_we_EX;
    logic [31:0] instret;
    logic v4, as4, rw4, il4, rwb4, fa4, fb4;
    logic [3:0] ao4, instret4;
    logic [1:0] rs4, rsb4, gr4;
    logic [4:0] rd4, rdb4;
    logic [2:0] gw4;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    decode_ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .valid_in(valid_in), .stall(stall), .flush(flush),
        .valid_EX(valid_EX), .aluop_EX(aluop_EX), .alusrc_EX(alusrc_EX), .regsel_EX(regsel_EX),
        .regwrite_EX(regwrite_EX), .rd_EX(rd_EX), .gpio_we_EX(gpio_we_EX), .gpio_rsel_EX(gpio_rsel_EX),
        .illegal_EX(illegal_EX), .regwrite_WB(regwrite_WB), .rd_WB(rd_WB), .regsel_WB(regsel_WB),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .instret(instret)
    );

    decode_ctrl_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .valid_in(valid_in), .stall(stall), .flush(flush),
        .valid_EX(v4), .aluop_EX(ao4), .alusrc_EX(as4), .regsel_EX(rs4),
        .regwrite_EX(rw4), .rd_EX(rd4), .gpio_we_EX(gw4), .gpio_rsel_EX(gr4),
        .illegal_EX(il4), .regwrite_WB(rwb4), .rd_WB(rdb4), .regsel_WB(rsb4),
        .fwd_a(fa4), .fwd_b(fb4), .instret(instret4)
    );

    typedef struct {
        string name;
        logic [31:0] instr;
        logic vin;
        logic [19:0] exp;
    } vec_t;
    vec_t tv[$];

    function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] it(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction
    function automatic logic [31:0] cw(input logic [11:0] csr, input logic [2:0] f3, input logic [4:0] rd);
        return {csr, 5'd1, f3, rd, 7'h73};
    endfunction
    // {valid, aluop, alusrc, regsel, regwrite, rd, gpio_we, gpio_rsel, illegal}
    function automatic logic [19:0] ex(input logic v, input logic [3:0] op, input logic src, input logic [1:0] sel,
                                       input logic wr, input logic [4:0] rd, input logic [2:0] we,
                                       input logic [1:0] rs, input logic ill);
        return {v, op, src, sel, wr, rd, we, rs, ill};
    endfunction
    localparam logic [19:0] ILL = {1'b1, 18'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        valid_in = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic put(input logic [31:0] i, input logic v);
        instr = i;
        valid_in = v;
    endtask

    initial begin
        logic [31:0] add3, sub4, addi9, mul1;
        logic [19:0] mul_exp;
        int exp_cnt;
        add3 = rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        sub4 = rt(7'h20, 5'd5, 5'd3, 3'b000, 5'd4);
        addi9 = it(12'd5, 5'd1, 3'b000, 5'd9);
        mul1 = rt(7'h01, 5'd3, 5'd2, 3'b000, 5'd1);
`ifdef RV32M_EN
        mul_exp = ex(1, 4'b0101, 0, 2'b10, 1, 5'd1, 3'b000, 2'd0, 0);
`else
        mul_exp = ILL;
`endif
        tv.push_back('{"add", add3, 1'b1, ex(1, 4'b0011, 0, 2'b10, 1, 5'd3, 3'b000, 2'd0, 0)});
        tv.push_back('{"sub", sub4, 1'b1, ex(1, 4'b0100, 0, 2'b10, 1, 5'd4, 3'b000, 2'd0, 0)});
        tv.push_back('{"xor", rt(7'h00, 5'd2, 5'd1, 3'b100, 5'd7), 1'b1, ex(1, 4'b0010, 0, 2'b10, 1, 5'd7, 3'b000, 2'd0, 0)});
        tv.push_back('{"sra", rt(7'h20, 5'd2, 5'd1, 3'b101, 5'd8), 1'b1, ex(1, 4'b1010, 0, 2'b10, 1, 5'd8, 3'b000, 2'd0, 0)});
        tv.push_back('{"sltu", rt(7'h00, 5'd2, 5'd1, 3'b011, 5'd8), 1'b1, ex(1, 4'b1101, 0, 2'b10, 1, 5'd8, 3'b000, 2'd0, 0)});
        tv.push_back('{"and", rt(7'h00, 5'd2, 5'd1, 3'b111, 5'd2), 1'b1, ex(1, 4'b0000, 0, 2'b10, 1, 5'd2, 3'b000, 2'd0, 0)});
        tv.push_back('{"addi", addi9, 1'b1, ex(1, 4'b0011, 1, 2'b10, 1, 5'd9, 3'b000, 2'd0, 0)});
        tv.push_back('{"srai", it({7'h20, 5'd3}, 5'd1, 3'b101, 5'd10), 1'b1, ex(1, 4'b1010, 1, 2'b10, 1, 5'd10, 3'b000, 2'd0, 0)});
        tv.push_back('{"slli", it({7'h00, 5'd3}, 5'd1, 3'b001, 5'd10), 1'b1, ex(1, 4'b1000, 1, 2'b10, 1, 5'd10, 3'b000, 2'd0, 0)});
        tv.push_back('{"lui", {20'hABCDE, 5'd11, 7'h37}, 1'b1, ex(1, 4'b0000, 0, 2'b01, 1, 5'd11, 3'b000, 2'd0, 0)});
        tv.push_back('{"csr_out2", cw(12'hF02, 3'b001, 5'd5), 1'b1, ex(1, 4'b0000, 0, 2'b00, 0, 5'd0, 3'b100, 2'd0, 0)});
        tv.push_back('{"csr_in0", cw(12'hF00, 3'b001, 5'd6), 1'b1, ex(1, 4'b0000, 0, 2'b00, 1, 5'd6, 3'b000, 2'd0, 0)});
        tv.push_back('{"csr_in1", cw(12'hF01, 3'b001, 5'd6), 1'b1, ex(1, 4'b0000, 0, 2'b00, 1, 5'd6, 3'b000, 2'd1, 0)});
        tv.push_back('{"csr_f03", cw(12'hF03, 3'b001, 5'd6), 1'b1, ILL});
        tv.push_back('{"add_x0", rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 1'b1, ex(1, 4'b0011, 0, 2'b10, 0, 5'd0, 3'b000, 2'd0, 0)});
        tv.push_back('{"mul", mul1, 1'b1, mul_exp});
        tv.push_back('{"load_op", {12'd0, 5'd1, 3'b010, 5'd4, 7'h03}, 1'b1, ILL});
        tv.push_back('{"bad_f7", rt(7'h20, 5'd2, 5'd1, 3'b111, 5'd4), 1'b1, ILL});
        tv.push_back('{"slti", it(12'd1, 5'd1, 3'b010, 5'd4), 1'b1, ILL});
        tv.push_back('{"csrrs", cw(12'hF00, 3'b010, 5'd4), 1'b1, ILL});
        tv.push_back('{"bubble", add3, 1'b0, 20'd0});

        // reset state
        #2;
        check("reset_ex", {valid_EX, aluop_EX, alusrc_EX, regsel_EX, regwrite_EX, rd_EX, gpio_we_EX, gpio_rsel_EX, illegal_EX}, 0);
        check("reset_wb", {regwrite_WB, rd_WB, regsel_WB, fwd_a, fwd_b}, 0);
        check("reset_instret", instret, 0);
        rst_n = 1'b1;

        // decode table
        exp_cnt = 0;
        foreach (tv[i]) begin
            put(tv[i].instr, tv[i].vin);
            tick;
            check(tv[i].name, {12'd0, valid_EX, aluop_EX, alusrc_EX, regsel_EX, regwrite_EX, rd_EX, gpio_we_EX, gpio_rsel_EX, illegal_EX},
                  {12'd0, tv[i].exp});
            if (i < tv.size() - 1 && tv[i].exp[19] && !tv[i].exp[0]) exp_cnt++;
        end
        check("table_instret", instret, exp_cnt);

        // back-to-back ADD/SUB with forwarding
        do_reset;
        put(add3, 1'b1);
        tick;
        put(sub4, 1'b1);
        #1;
        check("fwd_a_sub", {fwd_a, fwd_b}, 2'b10);
        check("ex_add", aluop_EX, 4'b0011);
        tick;
        check("ex_sub", aluop_EX, 4'b0100);
        check("wb_add", {regwrite_WB, rd_WB, regsel_WB}, {1'b1, 5'd3, 2'b10});
        put(rt(7'h00, 5'd4, 5'd0, 3'b000, 5'd9), 1'b1);
        #1;
        check("fwd_b_rs2", {fwd_a, fwd_b}, 2'b01);

        // stall held two cycles with ADDI in EX
        do_reset;
        put(addi9, 1'b1);
        tick;
        put(sub4, 1'b1);
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick;
            check("stall_ex", {valid_EX, aluop_EX, alusrc_EX, rd_EX}, {1'b1, 4'b0011, 1'b1, 5'd9});
            check("stall_wb", regwrite_WB, 0);
            check("stall_instret", instret, 0);
        end
        stall = 1'b0;
        tick;
        check("unstall_ex", aluop_EX, 4'b0100);
        check("unstall_wb", {regwrite_WB, rd_WB}, {1'b1, 5'd9});
        check("unstall_instret", instret, 1);
        stall = 1'b1;
        flush = 1'b1;
        tick;
        check("stall_flush_ex", {valid_EX, regwrite_EX, rd_EX}, 0);
        check("stall_flush_wb", regwrite_WB, 0);
        check("stall_flush_cnt", instret, 1);
        stall = 1'b0;
        flush = 1'b0;
        put(add3, 1'b1);
        tick;
        flush = 1'b1;
        put(sub4, 1'b1);
        tick;
        check("flush_ex", {valid_EX, aluop_EX, regwrite_EX}, 0);
        check("flush_wb", {regwrite_WB, rd_WB}, {1'b1, 5'd3});
        check("flush_instret", instret, 2);
        flush = 1'b0;

        // gpio_we one cycle per output CSRRW
        put(cw(12'hF02, 3'b001, 5'd5), 1'b1);
        tick;
        check("gpio_we_on", {gpio_we_EX, regwrite_EX}, {3'b100, 1'b0});
        put(add3, 1'b1);
        tick;
        check("gpio_we_off", gpio_we_EX, 3'b000);

        // MUL retire behaviour
        do_reset;
        put(mul1, 1'b1);
        tick;
        put(add3, 1'b0);
        tick;
`ifdef RV32M_EN
        check("mul_instret", instret, 1);
`else
        check("mul_instret", instret, 0);
`endif

        // async reset mid-cycle with ADD in EX
        do_reset;
        put(add3, 1'b1);
        tick;
        tick;
        put(rt(7'h00, 5'd3, 5'd3, 3'b000, 5'd1), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ex", {valid_EX, aluop_EX, regwrite_EX, rd_EX, regwrite_WB, rd_WB}, 0);
        check("async_rst_cnt", instret, 0);
        check("async_rst_fwd", {fwd_a, fwd_b}, 0);
        rst_n = 1'b1;

        // CNT_W=4 wrap after 17 retirements
        do_reset;
        put(add3, 1'b1);
        for (int n = 0; n < 17; n++) begin
            tick;
            if (n == 15) check("wrap_15", instret4, 15);
            if (n == 16) check("wrap_0", instret4, 0);
        end
        put(add3, 1'b0);
        tick;
        check("wrap_end", instret4, 1);
        check("wide_17", instret, 17);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
